// File: rtl/scheduler_ingress_pkg.sv
// scheduler_ingress_pkg.sv
// Shared widths, states and packet field helpers for the ingress path.
`ifndef SCHEDULER_INGRESS_PKG_SV
`define SCHEDULER_INGRESS_PKG_SV

`define SI_PKT_DELAY(p) p[scheduler_ingress_pkg::DW-1:0]
`define SI_PKT_AXON(p) \
  p[scheduler_ingress_pkg::PKT_W-1:scheduler_ingress_pkg::DW]

package scheduler_ingress_pkg;

  localparam int DEF_NUM_AXONS  = 256;
  localparam int DEF_NUM_TICKS  = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam int AW    = $clog2(DEF_NUM_AXONS);
  localparam int DW    = $clog2(DEF_NUM_TICKS);
  localparam int PKT_W = AW + DW;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    CLEAR   = 2'd2,
    ADVANCE = 2'd3
  } state_e;

endpackage

`endif

// File: rtl/scheduler_ingress_spike_fifo.sv
// spike_fifo.sv
// Synchronous FIFO for spike packets; overflow/underflow requests are ignored.
module spike_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == DEPTH[PTR_W:0];
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/scheduler_ingress.sv
// scheduler_ingress.sv
// Router-to-Scheduler ingress buffer with per-tick flush/clear/advance.
module scheduler_ingress
  import scheduler_ingress_pkg::*;
#(
  parameter int NUM_AXONS  = DEF_NUM_AXONS,
  parameter int NUM_TICKS  = DEF_NUM_TICKS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PW = $clog2(NUM_AXONS) + $clog2(NUM_TICKS),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_packet,
  output logic          sched_wen,
  output logic [PW-1:0] sched_packet,
  output logic          sched_clr,
  output logic          sched_set,
  input  logic          sched_error,
  output logic          tick_done,
  output logic [CW-1:0] occupancy,
  output logic          err_overrun,
  output logic          err_collision
);

  state_e        state;
  logic          alive;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [PW-1:0] head;

  // alive holds in_ready low until the first edge after reset release.
  assign in_ready = alive && !full && (state == RUN);
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (state == RUN || state == FLUSH);

  spike_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_packet),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      alive         <= 1'b0;
      sched_wen     <= 1'b0;
      sched_packet  <= '0;
      sched_clr     <= 1'b0;
      sched_set     <= 1'b0;
      tick_done     <= 1'b0;
      err_overrun   <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      alive     <= 1'b1;
      sched_wen <= pop;
      sched_clr <= 1'b0;
      sched_set <= 1'b0;
      tick_done <= 1'b0;
      if (pop) sched_packet <= head;
      if (tick && state != RUN) err_overrun <= 1'b1;
      if (sched_error && sched_wen) err_collision <= 1'b1;
      // Leaving FLUSH only when empty means no pop fires on
      // that edge, so the CLEAR cycle never carries a write.
      unique case (state)
        RUN: begin
          if (tick) state <= FLUSH;
        end
        FLUSH: begin
          if (empty) begin
            state     <= CLEAR;
            sched_clr <= 1'b1;
          end
        end
        CLEAR: begin
          state     <= ADVANCE;
          sched_set <= 1'b1;
          tick_done <= 1'b1;
        end
        ADVANCE: begin
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_scheduler_ingress.sv
// tb_scheduler_ingress.sv
// Randomized scoreboard bench for scheduler_ingress against a timing model.
module tb_scheduler_ingress;

  localparam int PW    = 12;
  localparam int CW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_packet = '0;
  logic          sched_error = 1'b0;
  logic          in_ready;
  logic          sched_wen;
  logic [PW-1:0] sched_packet;
  logic          sched_clr;
  logic          sched_set;
  logic          tick_done;
  logic [CW-1:0] occupancy;
  logic          err_overrun;
  logic          err_collision;

  always #5 clk = ~clk;

  scheduler_ingress dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_packet     (in_packet),
    .sched_wen     (sched_wen),
    .sched_packet  (sched_packet),
    .sched_clr     (sched_clr),
    .sched_set     (sched_set),
    .sched_error   (sched_error),
    .tick_done     (tick_done),
    .occupancy     (occupancy),
    .err_overrun   (err_overrun),
    .err_collision (err_collision)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, act, act, exp, exp);
    end
  endtask

  // Reference model: edge count e; a tick accepted at edge T with m
  // entries buffered yields clr after T+m+1, set after T+m+2, and
  // ready again after T+m+3. Every buffered entry drains at one/edge.
  logic [PW-1:0] exp_q[$];
  int   m_occ = 0;
  int   e = 0;
  int   busy_until = -1;
  int   clr_at = -1;
  int   set_at = -1;
  logic m_ready = 1'b0;
  logic m_wen = 1'b0;
  logic m_clr = 1'b0;
  logic m_set = 1'b0;
  logic m_ovr = 1'b0;
  logic m_coll = 1'b0;
  logic m_acc;
  logic m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_occ = 0;
      e = 0;
      busy_until = -1;
      clr_at = -1;
      set_at = -1;
      m_ready = 1'b0;
      m_wen = 1'b0;
      m_clr = 1'b0;
      m_set = 1'b0;
      m_ovr = 1'b0;
      m_coll = 1'b0;
    end else begin
      e++;
      m_acc = in_valid && m_ready;
      m_pop = m_occ > 0;
      if (sched_error && m_wen) m_coll = 1'b1;
      if (m_acc) exp_q.push_back(in_packet);
      m_occ = m_occ + int'(m_acc) - int'(m_pop);
      m_wen = m_pop;
      if (tick) begin
        if (e <= busy_until) m_ovr = 1'b1;
        else begin
          clr_at = e + m_occ + 1;
          set_at = e + m_occ + 2;
          busy_until = e + m_occ + 3;
        end
      end
      m_clr = (e == clr_at);
      m_set = (e == set_at);
      m_ready = (m_occ < DEPTH) && (e >= busy_until);
    end
  end

  logic [PW-1:0] exp_pkt;

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(m_ready));
    chk("sched_wen", int'(sched_wen), int'(m_wen));
    chk("sched_clr", int'(sched_clr), int'(m_clr));
    chk("sched_set", int'(sched_set), int'(m_set));
    chk("tick_done", int'(tick_done), int'(m_set));
    chk("occupancy", int'(occupancy), m_occ);
    chk("err_overrun", int'(err_overrun), int'(m_ovr));
    chk("err_collision", int'(err_collision), int'(m_coll));
    if (sched_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sched_packet at %0t: got 0x%0h, expected none",
                 $time, sched_packet);
      end else begin
        exp_pkt = exp_q.pop_front();
        chk("sched_packet", int'(sched_packet), int'(exp_pkt));
      end
    end
  end

  task automatic step(input logic v, input logic [PW-1:0] p,
                      input logic t, input logic er);
    @(posedge clk);
    #1;
    in_valid    = v;
    in_packet   = p;
    tick        = t;
    sched_error = er;
  endtask

  logic [PW-1:0] rp;

  initial begin
    // Reset with valid and tick asserted: nothing may be taken.
    rst = 1'b1;
    in_valid = 1'b1;
    in_packet = 12'hABC;
    tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    tick = 1'b0;
    step(0, '0, 0, 0);
    // Drain order.
    step(1, {8'd5, 4'd1}, 0, 0);
    step(1, {8'd17, 4'd2}, 0, 0);
    step(1, {8'd255, 4'd15}, 0, 0);
    repeat (5) step(0, '0, 0, 0);
    // Four packets then a tick; valid held through the sequence.
    for (int i = 0; i < 4; i++) step(1, PW'(12'h100 + i), 0, 0);
    step(1, 12'h777, 1, 0);
    for (int i = 0; i < 8; i++) step(1, PW'(12'h200 + i), 0, 0);
    repeat (4) step(0, '0, 0, 0);
    // Back-to-back ticks: overrun, one sequence.
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    repeat (8) step(0, '0, 0, 0);
    // Scheduler error with no write: no flag; then with a write.
    repeat (3) step(0, '0, 0, 1);
    step(1, 12'h3C5, 0, 1);
    repeat (4) step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    // Reset clears the sticky flags, then random traffic.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      rp = PW'($urandom);
      step($urandom_range(0, 9) < 7, rp,
           $urandom_range(0, 24) == 0,
           (i > 2000) && ($urandom_range(0, 63) == 0));
    end
    repeat (20) step(0, '0, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
